fp_mul_sched: RTL and testbench
===============================

# fp_mul_sched

Round-robin scheduler that shares one combinational IEEE-754 single-precision multiplier among `N_REQ` requesters. Each requester uses a valid/ready handshake to submit an operand pair. The scheduler registers the pair, drives the shared multiplier for `MUL_LAT` cycles, captures the product, and returns it to the granted requester through a per-requester response handshake. It sits between the requesters and the multiplier instance in the top level. The multiplier is instantiated outside this block.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 1: cycles the operands are held stable on the multiplier before the product is sampled, ≥1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: request pending, one bit per requester.
- `req_a` in `N_REQ*32`: operand A per requester; slice i is `[32i+31:32i]`.
- `req_b` in `N_REQ*32`: operand B per requester, same slicing.
- `req_ready` out `N_REQ`: one-hot acceptance.
- `resp_valid` out `N_REQ`: one-hot result available.
- `resp_ready` in `N_REQ`: requester takes the result.
- `resp_data` out 32: product {sign, exp[7:0], man[22:0]}.
- `mul_a`, `mul_b` out 32: operands to the shared multiplier.
- `mul_p` in 32: product from the shared multiplier.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → WAIT → RESP → IDLE.
- IDLE:
  - The grant `g` is the first requester with `req_valid` set, searching from `last_grant+1` upward and wrapping modulo `N_REQ`.
  - `req_ready[g]` is asserted combinationally; all other `req_ready` bits are 0.
  - Handshake completes on an edge where `req_valid[g]` and `req_ready[g]` are both high.
  - On that edge: `op_a`/`op_b` ← `req_a[g]`/`req_b[g]`, `grant_idx` ← g, `last_grant` ← g, `cnt` ← 0, go to WAIT.
- WAIT:
  - `mul_a`/`mul_b` = `op_a`/`op_b`.
  - `cnt` increments each cycle.
  - On the edge where `cnt == MUL_LAT-1`: `res` ← `mul_p`, go to RESP.
- RESP:
  - `resp_valid[grant_idx]` = 1 and `resp_data` = `res`.
  - On the edge where `resp_ready[grant_idx]` is high, go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- The block carries one transaction at a time. No new request is accepted in the RESP→IDLE cycle.
- Requesters hold `req_valid`, `req_a` and `req_b` stable until accepted. A valid deasserted before acceptance withdraws the request with no side effects.
- `mul_a`/`mul_b` hold their last values in IDLE and RESP. The multiplier output is ignored outside the capture edge.
- No arithmetic is performed here. `resp_data` is `mul_p` bit-exact.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n` low):
  - state IDLE; `last_grant` = `N_REQ-1`, so requester 0 has first priority.
  - `op_a`, `op_b`, `res`, `cnt`, `grant_idx` = 0.
  - `req_ready`, `resp_valid`, `busy` = 0; `resp_data`, `mul_a`, `mul_b` = 0.
- Latency: `resp_valid` rises `MUL_LAT` cycles after the acceptance edge.
- Minimum issue interval: `MUL_LAT+2` cycles per transaction with `resp_ready` tied high.
- If `resp_ready` is already high when `resp_valid` rises, the response lasts exactly 1 cycle.
- Simultaneous requests are resolved strictly round-robin. A requester that keeps `req_valid` high waits at most `N_REQ-1` other transactions.
- A requester whose grant pointer wraps past `N_REQ-1` is handled the same as index 0 after `N_REQ-1`.
- Reset asserted mid-transaction discards it: no response is issued and the pointer returns to its reset value.
- `req_ready` is combinational from `req_valid` and the state. `resp_valid` and `resp_data` come from registers only.

## Structure
- Package `fp_mul_sched_pkg`:
  - state enum `{IDLE, WAIT, RESP}`;
  - `FP_W = 32`;
  - field constants `SIGN_BIT = 31`, `EXP_MSB = 30`, `EXP_LSB = 23`, `MAN_W = 23`.
- Sub-module `rr_arbiter`, parameterised by `N_REQ`:
  - inputs `req` and `last_grant`;
  - outputs a one-hot `gnt`, its index, and `any`.
- The top-level FSM, registers and counter live in `fp_mul_sched`.

## Test plan
- Single request: requester 0 sends `a = 0x40200000` (2.5) and `b = 0x40200000` with `resp_ready` high, `MUL_LAT = 1`. Expect `req_ready[0]` for 1 cycle, `resp_valid[0]` one cycle after acceptance, `resp_data = 0x40C80000` (6.25).
- Sign handling: requester 2 sends `0xC0200000 × 0x40000000` (−2.5 × 2.0). Expect `resp_data = 0xC0A00000` on `resp_valid = 4'b0100` only.
- Round-robin: all four `req_valid` held high with distinct operands. Expect grant order 0, 1, 2, 3, 0, with each `resp_valid` one-hot matching the grant.
- Back-pressure: hold `resp_ready[1]` low for 5 cycles. Expect `resp_valid[1]` and `resp_data` stable, `busy` = 1, and `req_ready` all 0 throughout. IDLE follows one cycle after `resp_ready[1]` rises.
- `MUL_LAT = 3`: expect `mul_a`/`mul_b` stable for 3 cycles and `resp_valid` exactly 3 cycles after acceptance.
- Reset mid-WAIT: drop `rst_n` while in WAIT. Expect all outputs 0 immediately, no `resp_valid` after release, and requester 0 granted first again.

Source files
------------

// File: rtl/fp_mul_sched_pkg.sv
// fp_mul_sched_pkg: shared state encoding and IEEE-754 single-precision field constants.
package fp_mul_sched_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int FP_W = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W = 23;
endpackage

// File: rtl/fp_mul_sched_if.sv
// fp_mul_sched_if: requester handshakes plus the shared-multiplier operand/product bus.
interface fp_mul_sched_if #(parameter int N_REQ = 4) ();
  import fp_mul_sched_pkg::*;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] resp_valid;
  logic [N_REQ-1:0] resp_ready;
  logic [FP_W-1:0] resp_data;
  logic [FP_W-1:0] mul_a;
  logic [FP_W-1:0] mul_b;
  logic [FP_W-1:0] mul_p;
  logic busy;
  modport master (
    output req_valid, req_a, req_b, resp_ready, mul_p,
    input req_ready, resp_valid, resp_data, mul_a, mul_b, busy
  );
  modport slave (
    input req_valid, req_a, req_b, resp_ready, mul_p,
    output req_ready, resp_valid, resp_data, mul_a, mul_b, busy
  );
endinterface

// File: rtl/fp_mul_sched_rr_arbiter.sv
// rr_arbiter: picks the first set request after last_grant, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  // Scan farthest-first so the nearest requester after last_grant overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N_REQ]) begin
        idx = IW'((int'(last_grant) + k) % N_REQ);
        gnt = N_REQ'(1) << ((int'(last_grant) + k) % N_REQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin sharing of one external combinational FP32 multiplier.
module fp_mul_sched
  import fp_mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MUL_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  fp_mul_sched_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  state_t state;
  logic [FP_W-1:0] op_a, op_b, res;
  logic [CW-1:0] cnt;
  logic [IW-1:0] grant_idx, last_grant, idx;
  logic [N_REQ-1:0] gnt;
  logic any;
  rr_arbiter #(.N_REQ(N_REQ)) arb (
    .req(bus.req_valid),
    .last_grant(last_grant),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  assign bus.req_ready = state == IDLE ? gnt : '0;
  assign bus.resp_valid = state == RESP ? N_REQ'(1) << grant_idx : '0;
  assign bus.resp_data = res;
  // op_a/op_b only change on acceptance, so the multiplier inputs hold outside WAIT.
  assign bus.mul_a = op_a;
  assign bus.mul_b = op_b;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= IW'(N_REQ - 1);
      grant_idx <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      cnt <= '0;
    end else if (state == IDLE && any) begin
      op_a <= bus.req_a[int'(idx)*FP_W +: FP_W];
      op_b <= bus.req_b[int'(idx)*FP_W +: FP_W];
      grant_idx <= idx;
      last_grant <= idx;
      cnt <= '0;
      state <= WAIT;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(MUL_LAT - 1)) begin
        res <= bus.mul_p;
        state <= RESP;
      end
    end else if (state == RESP && bus.resp_ready[grant_idx]) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched: directed and randomized checks of the scheduler against a transaction-level model.
module tb_fp_mul_sched;
  import fp_mul_sched_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  int last = 3;
  logic [31:0] a [4];
  logic [31:0] b [4];
  fp_mul_sched_if #(.N_REQ(4)) bus0 ();
  fp_mul_sched_if #(.N_REQ(4)) bus1 ();
  fp_mul_sched #(.N_REQ(4), .MUL_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fp_mul_sched #(.N_REQ(4), .MUL_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;

  // Truncating FP32 multiply for normal operands; garbage when the scheduler is idle.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = 48'({1'b1, x[MAN_W-1:0]}) * 48'({1'b1, y[MAN_W-1:0]});
    e = int'(x[EXP_MSB:EXP_LSB]) + int'(y[EXP_MSB:EXP_LSB]) - 127;
    if (p[47]) begin
      e++;
      m = p[46:24];
    end else m = p[45:23];
    return {x[SIGN_BIT] ^ y[SIGN_BIT], 8'(e), m};
  endfunction
  assign bus0.mul_p = bus0.busy ? fmul(bus0.mul_a, bus0.mul_b) : 32'hDEADBEEF;
  assign bus1.mul_p = bus1.busy ? fmul(bus1.mul_a, bus1.mul_b) : 32'hDEADBEEF;

  function automatic int next_grant(input logic [3:0] v, input int l);
    for (int k = 1; k <= 4; k++) if (v[(l + k) % 4]) return (l + k) % 4;
    return 0;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [31:0] x, input logic [31:0] y);
    a[i] = x;
    b[i] = y;
    bus0.req_a[i*32 +: 32] = x;
    bus0.req_b[i*32 +: 32] = y;
    bus0.req_valid[i] = 1'b1;
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // One full transaction with resp_ready high; starts and ends at a negedge in IDLE.
  task automatic serve();
    int g, n;
    logic [31:0] e;
    #1;
    g = next_grant(bus0.req_valid, last);
    e = fmul(a[g], b[g]);
    chk(32'(bus0.req_ready), 32'(1 << g), "grant");
    @(posedge clk);
    #1 bus0.req_valid[g] = 1'b0;
    last = g;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (bus0.resp_valid == 0 && n < 10);
    chk(32'(n), 32'd1, "latency");
    chk(32'(bus0.resp_valid), 32'(1 << g), "resp_valid");
    chk(bus0.resp_data, e, "resp_data");
    chk(32'(bus0.busy), 32'd1, "busy_resp");
    @(posedge clk);
    @(negedge clk);
    chk(32'(bus0.resp_valid), 32'd0, "resp_one_cycle");
    chk(32'(bus0.busy), 32'd0, "idle_after_resp");
  endtask

  initial begin
    int n;
    logic [31:0] held;
    bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.resp_ready = '1;
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.resp_ready = '1;
    #3;
    chk(32'(bus0.req_ready), 0, "rst_req_ready");
    chk(32'(bus0.resp_valid), 0, "rst_resp_valid");
    chk(32'(bus0.busy), 0, "rst_busy");
    chk(bus0.resp_data, 0, "rst_resp_data");
    chk(bus0.mul_a, 0, "rst_mul_a");
    chk(bus0.mul_b, 0, "rst_mul_b");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // Round-robin with all four pending
    for (int i = 0; i < 4; i++) put(i, rnd_fp(), rnd_fp());
    repeat (4) serve();
    put(0, 32'h40200000, 32'h40200000);
    serve();
    chk(32'(last), 0, "rr_wrap_to_0");
    put(0, 32'h40200000, 32'h40200000);
    serve();
    put(2, 32'hC0200000, 32'h40000000);
    serve();
    chk(fmul(32'h40200000, 32'h40200000), 32'h40C80000, "model_6p25");
    chk(fmul(32'hC0200000, 32'h40000000), 32'hC0A00000, "model_neg5");
    // Back-pressure on requester 1 with requester 0 also waiting
    put(1, 32'h40200000, 32'h40200000);
    #1 chk(32'(bus0.req_ready), 32'b0010, "bp_grant");
    bus0.resp_ready[1] = 1'b0;
    @(posedge clk);
    #1 bus0.req_valid[1] = 1'b0;
    last = 1;
    put(0, rnd_fp(), rnd_fp());
    @(posedge clk);
    @(negedge clk);
    held = bus0.resp_data;
    chk(held, 32'h40C80000, "bp_data");
    for (int i = 0; i < 5; i++) begin
      chk(32'(bus0.resp_valid), 32'b0010, "bp_valid");
      chk(bus0.resp_data, held, "bp_stable");
      chk(32'(bus0.busy), 1, "bp_busy");
      chk(32'(bus0.req_ready), 0, "bp_req_ready");
      @(negedge clk);
    end
    bus0.resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(32'(bus0.busy), 0, "bp_release_idle");
    serve();
    // Randomized batches
    for (int r = 0; r < 8; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (m[i]) put(i, rnd_fp(), rnd_fp());
      n = 0;
      while (bus0.req_valid != 0 && n < 8) begin
        serve();
        n++;
      end
    end
    // MUL_LAT = 3 instance
    bus1.req_a[32 +: 32] = 32'h3FC00000;
    bus1.req_b[32 +: 32] = 32'hC0400000;
    bus1.req_valid = 4'b0010;
    #1 chk(32'(bus1.req_ready), 32'b0010, "l3_grant");
    @(posedge clk);
    #1 bus1.req_valid = '0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      chk(bus1.mul_a, 32'h3FC00000, "l3_mul_a");
      chk(bus1.mul_b, 32'hC0400000, "l3_mul_b");
    end while (bus1.resp_valid == 0 && n < 10);
    chk(32'(n), 3, "l3_latency");
    chk(32'(bus1.resp_valid), 32'b0010, "l3_resp_valid");
    chk(bus1.resp_data, 32'hC0900000, "l3_resp_data");
    // Reset during WAIT
    put(2, rnd_fp(), rnd_fp());
    #1 chk(32'(bus0.req_ready), 32'b0100, "rw_grant");
    @(posedge clk);
    #1 bus0.req_valid[2] = 1'b0;
    @(negedge clk);
    chk(32'(bus0.busy), 1, "rw_in_wait");
    rst_n = 0;
    #1;
    chk(32'(bus0.busy), 0, "rw_busy");
    chk(32'(bus0.resp_valid), 0, "rw_resp_valid");
    chk(bus0.resp_data, 0, "rw_resp_data");
    chk(bus0.mul_a, 0, "rw_mul_a");
    chk(bus0.mul_b, 0, "rw_mul_b");
    @(negedge clk);
    rst_n = 1;
    last = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(32'(bus0.resp_valid), 0, "rw_no_resp");
    end
    put(3, rnd_fp(), rnd_fp());
    put(0, rnd_fp(), rnd_fp());
    serve();
    chk(32'(last), 0, "rw_first_is_0");
    serve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
